piece_queue_hold: RTL and testbench

- Parametrised next-piece queue and hold slot for the Tetris game core.
- Supplies the active piece, a configurable-depth preview queue and a hold slot.
- Generates pieces with a 7-bag randomiser: every run of 7 consecutive generated pieces is one permutation of all 7 shapes.
- Sits between the control/input logic in tetris_game and the board and preview renderers.

---
 rtl/tetris_pkg.sv | 13 +
 rtl/bag_randomizer.sv | 43 ++++
 rtl/piece_queue_hold.sv | 70 +++++++
 tb/tb_piece_queue_hold.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: piece codes, piece width and queue FSM states shared by the Tetris core
package tetris_pkg;
  localparam int PIECE_W = 3;
  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_I = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_O = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_T = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_S = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_Z = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_J = 3'd6;
  localparam logic [PIECE_W-1:0] PIECE_L = 3'd7;
  typedef enum logic {FILL, RUN} state_t;
endpackage

// File: rtl/bag_randomizer.sv
// bag_randomizer: 7-bag piece generator driven by a free-running 16-bit Fibonacci LFSR
module bag_randomizer import tetris_pkg::*; #(
  parameter int PIECE_W = tetris_pkg::PIECE_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               gen,
  output logic [PIECE_W-1:0] piece
);
  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0] bag_q, bag_d, left;
  logic [2:0] idx, pos;
  logic [3:0] j;
  logic hit;
  // piece is valid every cycle; it is only consumed when gen is high
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    idx = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    pos = idx;
    hit = 1'b0;
    j = '0;
    for (int k = 0; k < 7; k++) begin
      j = 4'(idx) + 4'(k);
      j = (j > 4'd6) ? j - 4'd7 : j;
      if (!hit && bag_q[j[2:0]]) begin
        hit = 1'b1;
        pos = j[2:0];
      end
    end
    left = bag_q & ~(7'd1 << pos);
    piece = PIECE_W'(pos) + PIECE_W'(1);
  end
  assign bag_d = !gen ? bag_q : (left == '0) ? '1 : left;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
      bag_q <= '1;
    end else begin
      lfsr_q <= lfsr_d;
      bag_q <= bag_d;
    end
endmodule

// File: rtl/piece_queue_hold.sv
// piece_queue_hold: active piece, preview queue and hold slot fed by a 7-bag randomiser
module piece_queue_hold import tetris_pkg::*; #(
  parameter int QUEUE_DEPTH = 3,
  parameter int PIECE_W = tetris_pkg::PIECE_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           take,
  input  logic                           swap,
  output logic                           ready,
  output logic [PIECE_W-1:0]             current,
  output logic [QUEUE_DEPTH*PIECE_W-1:0] next_flat,
  output logic [PIECE_W-1:0]             hold,
  output logic                           hold_locked,
  output logic                           swap_done
);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [QUEUE_DEPTH-1:0][PIECE_W-1:0] slot_q, slot_d;
  logic [PIECE_W-1:0] current_q, current_d, hold_q, hold_d, piece;
  logic hold_locked_q, hold_locked_d, swap_done_q, swap_done_d;
  logic run, fill_gen, take_ok, swap_ok, adv;
  bag_randomizer #(.PIECE_W(PIECE_W), .LFSR_SEED(LFSR_SEED)) u_bag (
    .clock(clock), .reset_n(reset_n), .gen(adv), .piece(piece)
  );
  // a swap into an empty hold advances the queue exactly like a take
  always_comb begin
    run = state_q == RUN;
    fill_gen = !run && cnt_q <= 3'(QUEUE_DEPTH);
    take_ok = run && take;
    swap_ok = run && swap && !take && !hold_locked_q;
    adv = fill_gen || take_ok || (swap_ok && hold_q == PIECE_W'(PIECE_NONE));
    state_d = (!run && !fill_gen) ? RUN : state_q;
    cnt_d = fill_gen ? cnt_q + 3'd1 : cnt_q;
    slot_d = slot_q;
    if (adv) begin
      slot_d = slot_q >> PIECE_W;
      slot_d[QUEUE_DEPTH-1] = piece;
    end
    current_d = adv ? slot_q[0] : swap_ok ? hold_q : current_q;
    hold_d = swap_ok ? current_q : hold_q;
    hold_locked_d = take_ok ? 1'b0 : swap_ok ? 1'b1 : hold_locked_q;
    swap_done_d = swap_ok;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q <= '0;
      slot_q <= '0;
      current_q <= '0;
      hold_q <= '0;
      hold_locked_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      current_q <= current_d;
      hold_q <= hold_d;
      hold_locked_q <= hold_locked_d;
      swap_done_q <= swap_done_d;
    end
  assign ready = state_q == RUN;
  assign current = current_q;
  assign next_flat = slot_q;
  assign hold = hold_q;
  assign hold_locked = hold_locked_q;
  assign swap_done = swap_done_q;
endmodule

// File: tb/tb_piece_queue_hold.sv
// tb_piece_queue_hold: scoreboard bench with a behavioural queue/hold/7-bag model
module tb_piece_queue_hold;
  logic clock = 1'b0, reset_n = 1'b0, take = 1'b0, swap = 1'b0;
  logic ready, hold_locked, swap_done;
  logic [2:0] current, hold;
  logic [8:0] next_flat;
  typedef struct packed {
    logic       rdy;
    logic [2:0] cur;
    logic [8:0] nxt;
    logic [2:0] hld;
    logic       lk;
    logic       sd;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  logic [15:0] m_lfsr;
  logic [6:0] m_bag;
  logic [2:0] m_cur, m_hold;
  logic [2:0] m_q[3];
  logic m_locked, m_run;
  int m_cnt;
  int dut_log[$];
  always #10 clock = ~clock;
  piece_queue_hold #(.QUEUE_DEPTH(3), .PIECE_W(3), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset_n(reset_n), .take(take), .swap(swap), .ready(ready),
    .current(current), .next_flat(next_flat), .hold(hold),
    .hold_locked(hold_locked), .swap_done(swap_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_reset;
    m_lfsr = 16'hACE1;
    m_bag = '1;
    m_cur = '0;
    m_hold = '0;
    m_q = '{default: 3'd0};
    m_locked = 1'b0;
    m_run = 1'b0;
    m_cnt = 0;
  endtask
  task automatic m_gen(output logic [2:0] p);
    int idx, b;
    idx = int'(m_lfsr[2:0]);
    if (idx == 7) idx = 0;
    p = '0;
    for (int k = 0; k < 7; k++) begin
      b = (idx + k) % 7;
      if (p == 0 && m_bag[b]) begin
        p = 3'(b + 1);
        m_bag[b] = 1'b0;
      end
    end
    if (m_bag == '0) m_bag = '1;
  endtask
  task automatic step(input logic t, input logic s);
    logic adv, sd;
    logic [2:0] p;
    exp_t e;
    take = t;
    swap = s;
    adv = 1'b0;
    sd = 1'b0;
    p = '0;
    if (!m_run) begin
      if (m_cnt <= 3) begin
        adv = 1'b1;
        m_cnt++;
      end else m_run = 1'b1;
    end else if (t) begin
      adv = 1'b1;
      m_locked = 1'b0;
    end else if (s && !m_locked) begin
      sd = 1'b1;
      m_locked = 1'b1;
      if (m_hold == 0) begin
        m_hold = m_cur;
        adv = 1'b1;
      end else begin
        p = m_cur;
        m_cur = m_hold;
        m_hold = p;
      end
    end
    if (adv) begin
      m_gen(p);
      m_cur = m_q[0];
      m_q[0] = m_q[1];
      m_q[1] = m_q[2];
      m_q[2] = p;
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    sb.push_back('{m_run, m_cur, {m_q[2], m_q[1], m_q[0]}, m_hold, m_locked, sd});
    @(posedge clock);
    #1;
    take = 1'b0;
    swap = 1'b0;
    e = sb.pop_front();
    chk("ready", 32'(ready), 32'(e.rdy));
    chk("current", 32'(current), 32'(e.cur));
    chk("next_flat", 32'(next_flat), 32'(e.nxt));
    chk("hold", 32'(hold), 32'(e.hld));
    chk("hold_locked", 32'(hold_locked), 32'(e.lk));
    chk("swap_done", 32'(swap_done), 32'(e.sd));
  endtask
  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"}, 32'(ready), 0);
    chk({pfx, "_current"}, 32'(current), 0);
    chk({pfx, "_next_flat"}, 32'(next_flat), 0);
    chk({pfx, "_hold"}, 32'(hold), 0);
    chk({pfx, "_hold_locked"}, 32'(hold_locked), 0);
    chk({pfx, "_swap_done"}, 32'(swap_done), 0);
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    take = 1'b0;
    swap = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("rst");
    @(negedge clock);
    m_reset();
    reset_n = 1'b1;
  endtask
  task automatic fill_up(output int n);
    n = 0;
    while (n < 20) begin
      step(1'b0, 1'b0);
      n++;
      if (ready === 1'b1) break;
    end
  endtask
  initial begin
    int n, mask, p;
    logic [2:0] c, h, nx;
    do_reset();
    fill_up(n);
    chk("ready_latency", 32'(n), 5);
    chk("hold_empty", 32'(hold), 0);
    chk("cur_nonzero", 32'(current != 0), 1);
    chk("slot0_nonzero", 32'(next_flat[2:0] != 0), 1);
    chk("slot1_nonzero", 32'(next_flat[5:3] != 0), 1);
    chk("slot2_nonzero", 32'(next_flat[8:6] != 0), 1);
    dut_log.push_back(int'(current));
    dut_log.push_back(int'(next_flat[2:0]));
    dut_log.push_back(int'(next_flat[5:3]));
    dut_log.push_back(int'(next_flat[8:6]));
    repeat (14) begin
      step(1'b1, 1'b0);
      dut_log.push_back(int'(next_flat[8:6]));
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    for (int g = 0; g < 2; g++) begin
      mask = 0;
      for (int i = 0; i < 7; i++) begin
        p = dut_log[g * 7 + i];
        if (p >= 1 && p <= 7) mask |= 1 << (p - 1);
      end
      chk($sformatf("bag%0d_perm", g), 32'(mask), 32'h7f);
    end
    c = m_cur;
    nx = m_q[0];
    step(1'b0, 1'b1);
    chk("swap_hold", 32'(hold), 32'(c));
    chk("swap_current", 32'(current), 32'(nx));
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("take_unlocks", 32'(hold_locked), 0);
    step(1'b0, 1'b0);
    c = m_cur;
    h = m_hold;
    step(1'b0, 1'b1);
    chk("xchg_current", 32'(current), 32'(h));
    chk("xchg_hold", 32'(hold), 32'(c));
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    h = m_hold;
    step(1'b1, 1'b1);
    chk("both_hold", 32'(hold), 32'(h));
    chk("both_swap_done", 32'(swap_done), 0);
    step(1'b0, 1'b0);
    swap = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async");
    swap = 1'b0;
    do_reset();
    fill_up(n);
    chk("ready_latency2", 32'(n), 5);
    repeat (8) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
